// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for the DIV/DIVU datapath.
// One quotient bit is produced per clock by shift-and-subtract on operand
// magnitudes; signs are re-applied when the result is registered.
// Optional build macro: SEQDIV_EARLY_OUT_EN. When it is defined, a division
// whose divisor magnitude exceeds the dividend magnitude skips the iteration
// phase. Results are identical in both builds; only latency differs.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] rem_acc;   // partial remainder
  logic [WIDTH-1:0] quo_acc;   // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] div_mag;
  logic [CW-1:0]    count;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic             dvd_neg;
  logic             dsr_neg;
  logic [WIDTH-1:0] dvd_mag_in;
  logic [WIDTH-1:0] dsr_mag_in;
  logic signed [WIDTH:0] trial;

  // Two's-complement negation when requested; the most-negative value maps
  // onto itself, which is the correct unsigned magnitude 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                               input logic             neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign dvd_neg    = is_signed & dividend[WIDTH-1];
  assign dsr_neg    = is_signed & divisor[WIDTH-1];
  assign dvd_mag_in = cond_neg(dividend, dvd_neg);
  assign dsr_mag_in = cond_neg(divisor, dsr_neg);

  // Shifted partial remainder minus divisor, one bit wider so the sign of the
  // difference is exact even when the divisor magnitude uses the top bit.
  assign trial = $signed({rem_acc, quo_acc[WIDTH-1]} - {1'b0, div_mag});

  assign busy = (state == CALC) || (state == FINISH);

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem_acc     <= '0;
      quo_acc     <= '0;
      div_mag     <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count <= CNT_INIT;
            if (divisor == '0) begin
              // Preload the final values so FINISH needs no special case.
              quo_acc <= '1;
              rem_acc <= dividend;
              div_mag <= '0;
              neg_q   <= 1'b0;
              neg_r   <= 1'b0;
              dz      <= 1'b1;
              state   <= FINISH;
            end
`ifdef SEQDIV_EARLY_OUT_EN
            else if (dsr_mag_in > dvd_mag_in) begin
              quo_acc <= '0;
              rem_acc <= dvd_mag_in;
              div_mag <= dsr_mag_in;
              neg_q   <= dvd_neg ^ dsr_neg;
              neg_r   <= dvd_neg;
              dz      <= 1'b0;
              state   <= FINISH;
            end
`endif
            else begin
              quo_acc <= dvd_mag_in;
              rem_acc <= '0;
              div_mag <= dsr_mag_in;
              neg_q   <= dvd_neg ^ dsr_neg;
              neg_r   <= dvd_neg;
              dz      <= 1'b0;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (trial >= 0) begin
            rem_acc <= trial[WIDTH-1:0];
            quo_acc <= {quo_acc[WIDTH-2:0], 1'b1};
          end else begin
            // A failed trial implies the shifted remainder fits in WIDTH bits.
            rem_acc <= {rem_acc[WIDTH-2:0], quo_acc[WIDTH-1]};
            quo_acc <= {quo_acc[WIDTH-2:0], 1'b0};
          end
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          quotient    <= cond_neg(quo_acc, neg_q);
          remainder   <= cond_neg(rem_acc, neg_r);
          div_by_zero <= dz;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against an
// arithmetic reference model (integer / and % on sign-extended operands).
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: truncating integer division in 64-bit arithmetic.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, output logic [W-1:0] q,
                                output logic [W-1:0] r, output logic dz,
                                output int lat);
    longint sa, sb, aa, ab, lq, lr;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    aa = (sa < 0) ? -sa : sa;
    ab = (sb < 0) ? -sb : sb;
    if (sb == 0) begin
      q   = '1;
      r   = a;
      dz  = 1'b1;
      lat = 1;
    end else begin
      lq  = sa / sb;
      lr  = sa % sb;
      q   = lq[W-1:0];
      r   = lr[W-1:0];
      dz  = 1'b0;
      lat = W + 1;
`ifdef SEQDIV_EARLY_OUT_EN
      if (ab > aa) lat = 1;
`endif
    end
  endfunction

  // Issue one division, optionally pulse start at edge 5, and check it.
  // Returns at #1 after the done edge so a caller may chain immediately.
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                     input bit poke, output logic [W-1:0] eq, output logic [W-1:0] er,
                     output logic edz);
    int elat, n, busy_n;
    bit seen;
    model(a, b, s, eq, er, edz, elat);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    busy_n = busy ? 1 : 0;
    n      = 0;
    seen   = 1'b0;
    while (!seen && n < 3 * W) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
      else if (busy) busy_n++;
      if (poke && n == 4) begin
        start     = 1'b1;
        dividend  = ~a;
        divisor   = b + 1;
        is_signed = ~s;
      end
      if (poke && n == 5) start = 1'b0;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("latency", 64'(n), 64'(elat));
    chk("busy_cycles", 64'(busy_n), 64'(elat));
    chk("busy_in_done", 64'(busy), 64'd0);
    chk("quotient", 64'(quotient), 64'(eq));
    chk("remainder", 64'(remainder), 64'(er));
    chk("div_by_zero", 64'(div_by_zero), 64'(edz));
  endtask

  task automatic hold_chk(input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("done_pulse", 64'(done), 64'd0);
      chk("q_hold", 64'(quotient), 64'(eq));
      chk("r_hold", 64'(remainder), 64'(er));
      chk("dz_hold", 64'(div_by_zero), 64'(edz));
    end
  endtask

  initial begin
    logic [W-1:0] eq, er, a, b;
    logic edz, s;
    int seen_done;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_q", 64'(quotient), 64'd0);
    chk("rst_r", 64'(remainder), 64'd0);
    chk("rst_dz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(32'd100, 32'd7, 1'b0, 1'b0, eq, er, edz);
    chk("u100_7_q", 64'(quotient), 64'd14);
    chk("u100_7_r", 64'(remainder), 64'd2);
    hold_chk(eq, er, edz);
    run(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0, eq, er, edz);
    chk("sm100_7_q", 64'(quotient), 64'hFFFF_FFF2);
    chk("sm100_7_r", 64'(remainder), 64'hFFFF_FFFE);
    hold_chk(eq, er, edz);
    run(32'd100, 32'hFFFF_FFF9, 1'b1, 1'b0, eq, er, edz);
    chk("s100_m7_q", 64'(quotient), 64'hFFFF_FFF2);
    chk("s100_m7_r", 64'(remainder), 64'd2);
    hold_chk(eq, er, edz);
    run(32'h1234_5678, 32'd0, 1'b0, 1'b0, eq, er, edz);
    chk("dz_q", 64'(quotient), 64'hFFFF_FFFF);
    chk("dz_r", 64'(remainder), 64'h1234_5678);
    chk("dz_flag", 64'(div_by_zero), 64'd1);
    hold_chk(eq, er, edz);
    run(32'd9, 32'd3, 1'b0, 1'b0, eq, er, edz);
    chk("dz_clear", 64'(div_by_zero), 64'd0);
    chk("u9_3_q", 64'(quotient), 64'd3);
    hold_chk(eq, er, edz);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, eq, er, edz);
    chk("ovf_q", 64'(quotient), 64'h8000_0000);
    chk("ovf_r", 64'(remainder), 64'd0);
    hold_chk(eq, er, edz);
    run(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, eq, er, edz);
    chk("umax_q", 64'(quotient), 64'hFFFF_FFFF);
    hold_chk(eq, er, edz);
    run(32'd1000, 32'd3, 1'b0, 1'b1, eq, er, edz);
    chk("poke_q", 64'(quotient), 64'd333);
    hold_chk(eq, er, edz);
    run(32'd50, 32'd6, 1'b0, 1'b0, eq, er, edz);
    run(32'd77, 32'hFFFF_FFFB, 1'b1, 1'b0, eq, er, edz);
    chk("b2b_q", 64'(quotient), 64'hFFFF_FFF1);
    chk("b2b_r", 64'(remainder), 64'd2);
    run(32'd5, 32'd9, 1'b0, 1'b0, eq, er, edz);
    chk("small_q", 64'(quotient), 64'd0);
    chk("small_r", 64'(remainder), 64'd5);
    hold_chk(eq, er, edz);

    // Reset in the middle of an operation.
    dividend  = 32'd1000;
    divisor   = 32'd3;
    is_signed = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_q", 64'(quotient), 64'd0);
    chk("mid_rst_r", 64'(remainder), 64'd0);
    chk("mid_rst_dz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    chk("no_done_after_rst", 64'(seen_done), 64'd0);
    run(32'd1000, 32'd3, 1'b0, 1'b0, eq, er, edz);
    chk("post_rst_q", 64'(quotient), 64'd333);
    chk("post_rst_r", 64'(remainder), 64'd1);
    hold_chk(eq, er, edz);

    // Randomized operands with extra weight on edge-case divisors.
    for (int i = 0; i < 250; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 15) == 0) a = $urandom_range(0, 20);
      case ($urandom_range(0, 9))
        0:       b = '0;
        1, 2, 3: b = $urandom_range(1, 15);
        4:       b = '1;
        5:       b = 32'h8000_0000;
        6:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      run(a, b, s, 1'b0, eq, er, edz);
      if ($urandom_range(0, 1) == 1) hold_chk(eq, er, edz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
